// File: rtl/osd_text_render.sv
`default_nettype none
// ============================================================================
// Module   : osd_text_render
// Purpose  : Holds a 2-line x 16-column character buffer and renders it,
//            through an external 8x16 font ROM, into a 32-row x 128-bit
//            monochrome bitmap. Rendering fills a shadow bitmap that is
//            copied to the char0..char31 outputs only on a vsync edge, so
//            the downstream overlay never sees a half-drawn frame.
// Ports    : pclk, rst_n (async, active-low)
//            vs_in                      raw vsync, frame edge = entry into VS_POL
//            wr_en/wr_addr/wr_code      text cell write, one per cycle
//            font_addr/font_data        font ROM, data 1 cycle after address
//            busy                       render in progress
//            frame_done                 1-cycle pulse when the shadow is complete
//            char0..char31              committed bitmap rows, pixel x = bit 127-x
//            cursor_on/cursor_pos       only with OSD_TEXT_CURSOR_EN defined
// Options  : OSD_TEXT_CURSOR_EN - adds an inverted-video cursor cell.
// Revision : 1.0 - initial release
// ============================================================================
module osd_text_render #(
    parameter logic       VS_POL     = 1'b1,
    parameter logic [7:0] BLANK_CODE = 8'h20
) (
    input  logic         pclk,
    input  logic         rst_n,
    input  logic         vs_in,
    input  logic         wr_en,
    input  logic [4:0]   wr_addr,
    input  logic [7:0]   wr_code,
`ifdef OSD_TEXT_CURSOR_EN
    input  logic         cursor_on,
    input  logic [4:0]   cursor_pos,
`endif
    output logic [11:0]  font_addr,
    input  logic [7:0]   font_data,
    output logic         busy,
    output logic         frame_done,
    output logic [127:0] char0,  output logic [127:0] char1,
    output logic [127:0] char2,  output logic [127:0] char3,
    output logic [127:0] char4,  output logic [127:0] char5,
    output logic [127:0] char6,  output logic [127:0] char7,
    output logic [127:0] char8,  output logic [127:0] char9,
    output logic [127:0] char10, output logic [127:0] char11,
    output logic [127:0] char12, output logic [127:0] char13,
    output logic [127:0] char14, output logic [127:0] char15,
    output logic [127:0] char16, output logic [127:0] char17,
    output logic [127:0] char18, output logic [127:0] char19,
    output logic [127:0] char20, output logic [127:0] char21,
    output logic [127:0] char22, output logic [127:0] char23,
    output logic [127:0] char24, output logic [127:0] char25,
    output logic [127:0] char26, output logic [127:0] char27,
    output logic [127:0] char28, output logic [127:0] char29,
    output logic [127:0] char30, output logic [127:0] char31
);

    localparam logic [2:0] c_ST_IDLE  = 3'd0;
    localparam logic [2:0] c_ST_RD    = 3'd1;
    localparam logic [2:0] c_ST_LAST  = 3'd2;
    localparam logic [2:0] c_ST_STORE = 3'd3;
    localparam logic [2:0] c_ST_DONE  = 3'd4;
    localparam logic [3:0] c_LAST_COL = 4'd15;
    localparam logic [4:0] c_LAST_ROW = 5'd31;

    logic [7:0]   r_text   [32];
    logic [7:0]   r_snap   [32];
    logic [127:0] r_shadow [32];
    logic [127:0] r_char   [32];
    logic [127:0] r_shift;
    logic         r_vs_d;
    logic         r_dirty;
    logic         r_shadow_valid;
    logic [2:0]   r_state;
    logic [2:0]   w_next_state;
    logic [4:0]   r_row;
    logic [3:0]   r_col;
    logic [11:0]  r_font_addr_hold;
    logic [11:0]  w_rd_addr;
    logic [7:0]   w_glyph;
    logic         w_vs_edge;
    logic         w_start;
    logic         w_commit;

    assign w_vs_edge = (vs_in == VS_POL) && (r_vs_d != VS_POL);
    assign w_start   = w_vs_edge && (r_state == c_ST_IDLE) && r_dirty;
    // shadow_valid is never set while a render is running, so this cannot
    // fire mid-render.
    assign w_commit  = w_vs_edge && r_shadow_valid;

    assign w_rd_addr = {r_snap[{r_row[4], r_col}], r_row[3:0]};

`ifdef OSD_TEXT_CURSOR_EN
    logic       r_cur_on;
    logic [4:0] r_cur_pos;
    logic [3:0] w_prev_col;

    // font_data belongs to the column addressed one cycle earlier; in LAST
    // r_col has wrapped to 0, so the subtraction yields column 15.
    assign w_prev_col = r_col - 4'd1;
    assign w_glyph    = (r_cur_on && (r_cur_pos == {r_row[4], w_prev_col}))
                        ? ~font_data : font_data;
`else
    assign w_glyph    = font_data;
`endif

    // Text buffer, vsync history and dirty flag
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            // Start from the active level so a vsync already asserted at
            // reset release is not mistaken for a frame edge.
            r_vs_d  <= VS_POL;
            r_dirty <= 1'b1;
            for (int i = 0; i < 32; i++) r_text[i] <= BLANK_CODE;
        end else begin
            r_vs_d <= vs_in;
            if (wr_en) begin
                r_text[wr_addr] <= wr_code;
                r_dirty         <= 1'b1;   // wins over a coincident start
            end else if (w_start) begin
                r_dirty <= 1'b0;
            end
        end
    end

    // FSM state register
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) r_state <= c_ST_IDLE;
        else        r_state <= w_next_state;
    end

    // FSM next state
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_ST_IDLE:  if (w_start) w_next_state = c_ST_RD;
            c_ST_RD:    if (r_col == c_LAST_COL) w_next_state = c_ST_LAST;
            c_ST_LAST:  w_next_state = c_ST_STORE;
            c_ST_STORE: w_next_state = (r_row == c_LAST_ROW) ? c_ST_DONE : c_ST_RD;
            c_ST_DONE:  w_next_state = c_ST_IDLE;
            default:    w_next_state = c_ST_IDLE;
        endcase
    end

    // Render datapath: snapshot, address walk, row assembly, shadow store
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            r_row            <= 5'd0;
            r_col            <= 4'd0;
            r_shift          <= '0;
            r_font_addr_hold <= 12'd0;
            r_shadow_valid   <= 1'b0;
            for (int i = 0; i < 32; i++) begin
                r_snap[i]   <= BLANK_CODE;
                r_shadow[i] <= '0;
            end
`ifdef OSD_TEXT_CURSOR_EN
            r_cur_on  <= 1'b0;
            r_cur_pos <= 5'd0;
`endif
        end else begin
            if (w_start) begin
                for (int i = 0; i < 32; i++) r_snap[i] <= r_text[i];
                r_row <= 5'd0;
                r_col <= 4'd0;
`ifdef OSD_TEXT_CURSOR_EN
                r_cur_on  <= cursor_on;
                r_cur_pos <= cursor_pos;
`endif
            end

            case (r_state)
                c_ST_RD: begin
                    r_col            <= r_col + 4'd1;
                    r_font_addr_hold <= w_rd_addr;
                    // Column 0's glyph only arrives on the next cycle.
                    if (r_col != 4'd0) r_shift <= {r_shift[119:0], w_glyph};
                end
                c_ST_LAST: begin
                    r_shift <= {r_shift[119:0], w_glyph};
                end
                c_ST_STORE: begin
                    r_shadow[r_row] <= r_shift;
                    r_row           <= r_row + 5'd1;
                end
                default: ;
            endcase

            if (r_state == c_ST_DONE) r_shadow_valid <= 1'b1;
            else if (w_commit)        r_shadow_valid <= 1'b0;
        end
    end

    // Committed bitmap, updated only on a frame edge
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) r_char[i] <= '0;
        end else if (w_commit) begin
            for (int i = 0; i < 32; i++) r_char[i] <= r_shadow[i];
        end
    end

    // Address is live during RD and frozen at its last value otherwise.
    assign font_addr  = (r_state == c_ST_RD) ? w_rd_addr : r_font_addr_hold;
    assign busy       = (r_state == c_ST_RD) || (r_state == c_ST_LAST) ||
                        (r_state == c_ST_STORE);
    assign frame_done = (r_state == c_ST_DONE);

    assign char0  = r_char[0];   assign char1  = r_char[1];
    assign char2  = r_char[2];   assign char3  = r_char[3];
    assign char4  = r_char[4];   assign char5  = r_char[5];
    assign char6  = r_char[6];   assign char7  = r_char[7];
    assign char8  = r_char[8];   assign char9  = r_char[9];
    assign char10 = r_char[10];  assign char11 = r_char[11];
    assign char12 = r_char[12];  assign char13 = r_char[13];
    assign char14 = r_char[14];  assign char15 = r_char[15];
    assign char16 = r_char[16];  assign char17 = r_char[17];
    assign char18 = r_char[18];  assign char19 = r_char[19];
    assign char20 = r_char[20];  assign char21 = r_char[21];
    assign char22 = r_char[22];  assign char23 = r_char[23];
    assign char24 = r_char[24];  assign char25 = r_char[25];
    assign char26 = r_char[26];  assign char27 = r_char[27];
    assign char28 = r_char[28];  assign char29 = r_char[29];
    assign char30 = r_char[30];  assign char31 = r_char[31];

endmodule
`default_nettype wire
